ccc_clken_gen: RTL and testbench
================================

Name: ccc_clken_gen

Overview:
- Parametrised, multi-channel fabric clock-enable generator; successor to the fixed, single-source MSS clock-conditioning wrapper.
- Runs from one fabric clock (the RCOSC/CCC-derived GLA0 domain). Produces NUM_CH independently programmable divided enables and square-wave companions.
- Adds per-channel phase delay, bypass and glitch-free runtime reconfiguration, plus a settle/lock indicator.
- Peripherals use ce_out as clock enables; no derived clocks are created.

Parameters:
- NUM_CH, 3, number of output channels (1..8).
- DIV_W, 5, width of divide field; ratio N = div+1 (1..2^DIV_W).
- DLY_W, 5, width of phase-delay field (cycles).
- DIV_RST, 3, reset divide field per channel (N=4).
- LOCK_CYCLES, 16, quiet cycles required before lock asserts (>=1).

Ports:
- PCLK  in  1  fabric clock.
- PRESERN  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  3  target channel index.
- cfg_div  in  DIV_W  divide field.
- cfg_dly  in  DLY_W  phase delay field.
- cfg_bypass  in  1  1 = channel bypassed (ce every cycle).
- ch_en  in  NUM_CH  per-channel run enable.
- ce_out  out  NUM_CH  one-cycle enable pulse per divided period.
- gl_out  out  NUM_CH  square wave, toggles on each ce_out pulse.
- cfg_err  out  1  one-cycle pulse on write to cfg_ch >= NUM_CH.
- lock  out  1  all configuration applied and settled.

Behaviour:
- Reset (async assert, sync release): ce_out=0, gl_out=0, cfg_err=0, lock=0. Shadow and active div=DIV_RST, dly=0, bypass=0. Pending flags=0. Counters=0.
- Write: cfg_we with valid cfg_ch captures div/dly/bypass into that channel's shadow and sets pending. Two writes before apply: last wins. Invalid cfg_ch: shadow untouched, cfg_err=1 next cycle.
- Apply: pending shadow copies to active:
  - on the edge where the channel's ce_out is asserted (terminal count), or
  - on the next edge if the channel is disabled.
  - Applying clears pending, zeroes the divide counter and loads the delay counter with dly.
  - A write landing in the same cycle as a terminal count is applied at the following terminal count, not the current one.
- Run, per channel, with ch_en high and not bypassed:
  - Delay counter decrements to 0 first; ce_out is suppressed while it is nonzero.
  - Divide counter then counts 0..div; ce_out (registered) pulses for 1 cycle when the count reaches div, and the counter wraps to 0.
  - Timing: ch_en sampled high at edge 0 gives the first ce_out at edge D+N, then every N edges.
  - div=0: ce_out high every cycle once the delay has elapsed.
- Bypass: ce_out=1 every cycle while ch_en is high; gl_out toggles every cycle; delay ignored.
- gl_out: toggles on every cycle ce_out is asserted; period 2N.
- ch_en low: channel's counters clear to 0, ce_out=0 and gl_out=0 next edge; active config retained; pending still applies.
- ch_en rising: restarts with the delay phase, exactly as after an apply.
- Lock:
  - Quiet-cycle counter increments each cycle with no cfg_we, no ch_en change and no pending flag set.
  - lock=1 once the counter reaches LOCK_CYCLES; it saturates.
  - Any cfg_we (valid or not), any ch_en change, or any pending flag clears the counter, and lock=0 on the next edge.
- Reset mid-operation: everything returns to reset values immediately; lock requires LOCK_CYCLES after release.

Optional Feature:
- Macro: CCC_HALFDIV_EN.
- Defined:
  - cfg_half input (1 bit) is added and written to the shadow like the other fields.
  - Active half=1: alternating periods of N and N+1 cycles (average N+0.5); the first period after apply is N.
  - gl_out toggles per ce_out as normal.
  - Bypass overrides half.
- Undefined: no cfg_half port; all periods are exactly N.

Test Plan:
- Reset release, ch_en=3'b001, defaults -> ch0 ce_out at edges 4, 8, 12; gl_out ch0 period 8; ch1/ch2 outputs stay 0; lock=1 at edge 16 after the ch_en change.
- Write ch1 div=2, dly=5, then raise ch_en[1] -> first ch1 ce_out at edge 8 after the enable edge, then every 3; lock drops after the write and returns 16 quiet cycles later.
- ch0 running at div=3; write div=0 in the terminal-count cycle -> one more period of 4, then ce_out every cycle; no short or merged pulse.
- Write cfg_ch=5 with NUM_CH=3 -> cfg_err one pulse, no channel changes, lock cleared then regained.
- Bypass=1 on ch2 -> ce_out[2] constant 1, gl_out[2] toggles every cycle; drop ch_en[2] -> both 0 next edge.
- Define CCC_HALFDIV_EN: ch0 div=2, half=1 -> ce_out spacing 3, 4, 3, 4…; pull PRESERN low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ccc_clken_gen.sv
// ccc_clken_gen: multi-channel fabric clock-enable generator.
// Each channel produces a one-cycle ce_out pulse every N = div+1 cycles,
// after a programmable phase delay. gl_out is a square-wave companion that
// toggles on every pulse. Configuration is written to a per-channel shadow
// and copied to the active set at a terminal count, or on the next edge
// while the channel is disabled, so periods already in progress are never
// cut short. lock reports LOCK_CYCLES consecutive quiet cycles.
// Optional build macro CCC_HALFDIV_EN adds cfg_half. When the active half
// bit is set, periods alternate between N and N+1 cycles.
module ccc_clken_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 5,
  parameter int DLY_W       = 5,
  parameter int DIV_RST     = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DLY_W-1:0]  cfg_dly,
  input  logic              cfg_bypass,
`ifdef CCC_HALFDIV_EN
  input  logic              cfg_half,
`endif
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] gl_out,
  output logic              cfg_err,
  output logic              lock
);

  // One extra bit so a half-divide period of 2^DIV_W + 1 still fits.
  localparam int CNT_W = DIV_W + 1;
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] en_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] sh_div_q, act_div_q;
    logic [DLY_W-1:0] sh_dly_q, act_dly_q;
    logic             sh_byp_q, act_byp_q;
    logic             pend_q;
    logic             en_q;
    logic [DLY_W-1:0] dly_cnt_q;
    logic [CNT_W-1:0] div_cnt_q;
    logic             ce_q, gl_q;
    logic             wr_hit, rise, tc, apply;
    logic [CNT_W-1:0] term;

`ifdef CCC_HALFDIV_EN
    logic sh_half_q, act_half_q, ph_q;
    // ph_q selects the long (N+1) period on every other pulse.
    assign term = {1'b0, act_div_q} + CNT_W'(act_half_q & ph_q);
`else
    assign term = {1'b0, act_div_q};
`endif

    assign wr_hit = cfg_we && (cfg_ch == 3'(i));
    assign rise   = ch_en[i] & ~en_q;
    // Bypassed channels hit terminal count on every enabled cycle.
    assign tc     = ch_en[i] & (act_byp_q |
                    (~rise & (dly_cnt_q == '0) & (div_cnt_q == term)));
    assign apply  = pend_q & (tc | ~ch_en[i]);

    // Shadow capture, apply, delay and divide counting for one channel.
    always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
        sh_div_q  <= DIV_W'(DIV_RST);
        act_div_q <= DIV_W'(DIV_RST);
        sh_dly_q  <= '0;
        act_dly_q <= '0;
        sh_byp_q  <= 1'b0;
        act_byp_q <= 1'b0;
        pend_q    <= 1'b0;
        en_q      <= 1'b0;
        dly_cnt_q <= '0;
        div_cnt_q <= '0;
        ce_q      <= 1'b0;
        gl_q      <= 1'b0;
`ifdef CCC_HALFDIV_EN
        sh_half_q  <= 1'b0;
        act_half_q <= 1'b0;
        ph_q       <= 1'b0;
`endif
      end else begin
        en_q <= ch_en[i];

        // A write in the same cycle as an apply wins and stays pending.
        if (wr_hit) begin
          sh_div_q <= cfg_div;
          sh_dly_q <= cfg_dly;
          sh_byp_q <= cfg_bypass;
`ifdef CCC_HALFDIV_EN
          sh_half_q <= cfg_half;
`endif
          pend_q   <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end

        if (apply) begin
          act_div_q <= sh_div_q;
          act_dly_q <= sh_dly_q;
          act_byp_q <= sh_byp_q;
`ifdef CCC_HALFDIV_EN
          act_half_q <= sh_half_q;
`endif
        end

        if (!ch_en[i]) begin
          dly_cnt_q <= '0;
          div_cnt_q <= '0;
          ce_q      <= 1'b0;
          gl_q      <= 1'b0;
`ifdef CCC_HALFDIV_EN
          ph_q      <= 1'b0;
`endif
        end else if (act_byp_q) begin
          ce_q      <= 1'b1;
          gl_q      <= ~gl_q;
          div_cnt_q <= '0;
          dly_cnt_q <= apply ? sh_dly_q : '0;
`ifdef CCC_HALFDIV_EN
          ph_q      <= 1'b0;
`endif
        end else if (rise) begin
          dly_cnt_q <= act_dly_q;
          div_cnt_q <= '0;
          ce_q      <= 1'b0;
`ifdef CCC_HALFDIV_EN
          ph_q      <= 1'b0;
`endif
        end else if (dly_cnt_q != '0) begin
          dly_cnt_q <= dly_cnt_q - DLY_W'(1);
          ce_q      <= 1'b0;
        end else if (div_cnt_q == term) begin
          ce_q      <= 1'b1;
          gl_q      <= ~gl_q;
          div_cnt_q <= '0;
          if (apply) dly_cnt_q <= sh_dly_q;
`ifdef CCC_HALFDIV_EN
          ph_q      <= apply ? 1'b0 : ~ph_q;
`endif
        end else begin
          div_cnt_q <= div_cnt_q + CNT_W'(1);
          ce_q      <= 1'b0;
        end
      end
    end

    assign ce_out[i] = ce_q;
    assign gl_out[i] = gl_q;
    assign pend_w[i] = pend_q;
    assign en_w[i]   = en_q;
  end

  logic             disturb;
  logic [LCK_W-1:0] quiet_q, quiet_d;
  logic             lock_q, cfg_err_q;

  assign disturb = cfg_we | (ch_en != en_w) | (|pend_w);

  // Quiet-cycle counter: cleared by any disturbance, saturates at LOCK_CYCLES.
  always_comb begin
    quiet_d = quiet_q;
    if (disturb) quiet_d = '0;
    else if (quiet_q != LCK_W'(LOCK_CYCLES)) quiet_d = quiet_q + LCK_W'(1);
  end

  // Registered lock and out-of-range channel error pulse.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      quiet_q   <= '0;
      lock_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      quiet_q   <= quiet_d;
      lock_q    <= (quiet_d == LCK_W'(LOCK_CYCLES));
      cfg_err_q <= cfg_we && (32'(cfg_ch) >= NUM_CH);
    end
  end

  assign lock    = lock_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_ccc_clken_gen.sv
// Directed bench for ccc_clken_gen with default parameters.
// Half-divide vectors are compiled in only when CCC_HALFDIV_EN is defined.
module tb_ccc_clken_gen;

  logic       PCLK;
  logic       PRESERN;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [4:0] cfg_div;
  logic [4:0] cfg_dly;
  logic       cfg_bypass;
`ifdef CCC_HALFDIV_EN
  logic       cfg_half;
`endif
  logic [2:0] ch_en;
  logic [2:0] ce_out;
  logic [2:0] gl_out;
  logic       cfg_err;
  logic       lock;

  int checks = 0;
  int errors = 0;

  ccc_clken_gen dut (
    .PCLK       (PCLK),
    .PRESERN    (PRESERN),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_dly    (cfg_dly),
    .cfg_bypass (cfg_bypass),
`ifdef CCC_HALFDIV_EN
    .cfg_half   (cfg_half),
`endif
    .ch_en      (ch_en),
    .ce_out     (ce_out),
    .gl_out     (gl_out),
    .cfg_err    (cfg_err),
    .lock       (lock)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [4:0] dv, input logic [4:0] dl,
                           input logic byp);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_div    = dv;
    cfg_dly    = dl;
    cfg_bypass = byp;
  endtask

  logic [16:0] v_a, v_b, v_c, v_d;

  initial begin
    PRESERN = 1'b0; ch_en = 3'b000; cfg_we = 1'b0; cfg_ch = 3'd0;
    cfg_div = 5'd0; cfg_dly = 5'd0; cfg_bypass = 1'b0;
`ifdef CCC_HALFDIV_EN
    cfg_half = 1'b0;
`endif
    repeat (3) tick();
    chk_val("rst_ce", ce_out, 0);
    chk_val("rst_gl", gl_out, 0);
    chk_val("rst_err", cfg_err, 0);
    chk_val("rst_lock", lock, 0);

    // Defaults on ch0: pulses at edges 4,8,12,16; lock at edge 16.
    PRESERN = 1'b1;
    ch_en = 3'b001;
    v_a = '0; v_b = '0; v_c = '0; v_d = '0;
    for (int e = 0; e <= 16; e++) begin
      tick();
      v_a[e] = ce_out[0]; v_b[e] = gl_out[0]; v_c[e] = lock;
      v_d[e] = |{ce_out[2:1], gl_out[2:1]};
    end
    chk_val("t1_ce0", v_a, 17'h11110);
    chk_val("t1_gl0", v_b, 17'h0F0F0);
    chk_val("t1_lock", v_c, 17'h10000);
    chk_val("t1_idle12", v_d, 0);

    // ch1 div=2 dly=5, applied while disabled, then enabled.
    cfg_write(3'd1, 5'd2, 5'd5, 1'b0);
    tick();
    chk_val("t2_lock_drop", lock, 0);
    cfg_we = 1'b0;
    tick();
    ch_en = 3'b011;
    v_a = '0; v_b = '0; v_c = '0;
    for (int e = 0; e <= 16; e++) begin
      tick();
      v_a[e] = ce_out[1]; v_b[e] = lock; v_c[e] = ce_out[0];
    end
    chk_val("t2_ce1", v_a, 17'h04900);
    chk_val("t2_lock", v_b, 17'h10000);
    chk_val("t2_ce0", v_c, 17'h02222);

    // Write div=0 to ch0 in the cycle ending at its terminal count.
    cfg_write(3'd0, 5'd0, 5'd0, 1'b0);
    v_a = '0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 0) cfg_we = 1'b0;
      v_a[e] = ce_out[0];
    end
    chk_val("t3_ce0", v_a, 17'h007F1);

    // Out-of-range channel write.
    cfg_write(3'd5, 5'd7, 5'd9, 1'b1);
    v_a = '0; v_b = '0; v_c = '0; v_d = '0;
    for (int e = 0; e <= 16; e++) begin
      tick();
      if (e == 0) cfg_we = 1'b0;
      v_a[e] = cfg_err; v_b[e] = lock; v_c[e] = ce_out[0]; v_d[e] = ce_out[1];
    end
    chk_val("t4_err", v_a, 17'h00001);
    chk_val("t4_lock", v_b, 17'h10000);
    chk_val("t4_ce0", v_c, 17'h1FFFF);
    chk_val("t4_ce1", v_d, 17'h12492);

    // Bypass on ch2, then disable it.
    cfg_write(3'd2, 5'd3, 5'd0, 1'b1);
    tick();
    cfg_we = 1'b0;
    tick();
    ch_en = 3'b111;
    v_a = '0; v_b = '0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      v_a[e] = ce_out[2]; v_b[e] = gl_out[2];
    end
    chk_val("t5_ce2", v_a, 17'h0001F);
    chk_val("t5_gl2", v_b, 17'h00015);
    ch_en = 3'b011;
    tick();
    chk_val("t5_off_ce2", ce_out[2], 0);
    chk_val("t5_off_gl2", gl_out[2], 0);

    // Asynchronous reset mid-run, then defaults restored.
    chk_val("t6_pre_ce0", ce_out[0], 1);
    #2;
    PRESERN = 1'b0;
    #1;
    chk_val("t6_rst_ce", ce_out, 0);
    chk_val("t6_rst_gl", gl_out, 0);
    chk_val("t6_rst_lock", lock, 0);
    tick();
    PRESERN = 1'b1;
    v_a = '0; v_b = '0; v_c = '0;
    for (int e = 0; e <= 16; e++) begin
      tick();
      v_a[e] = ce_out[0]; v_b[e] = ce_out[1]; v_c[e] = lock;
    end
    chk_val("t6_ce0", v_a, 17'h11110);
    chk_val("t6_ce1", v_b, 17'h11110);
    chk_val("t6_lock", v_c, 17'h10000);

`ifdef CCC_HALFDIV_EN
    // Half-divide on ch0: spacing 3,4,3,4 after enable.
    ch_en = 3'b010;
    cfg_write(3'd0, 5'd2, 5'd0, 1'b0);
    cfg_half = 1'b1;
    tick();
    cfg_we = 1'b0;
    cfg_half = 1'b0;
    tick();
    ch_en = 3'b011;
    v_a = '0;
    for (int e = 0; e <= 14; e++) begin
      tick();
      v_a[e] = ce_out[0];
    end
    chk_val("t7_half_ce0", v_a, 17'h04488);
    #2;
    PRESERN = 1'b0;
    #1;
    chk_val("t7_rst_ce", ce_out, 0);
    chk_val("t7_rst_gl", gl_out, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
